// File: rtl/arriskv_pkg.sv
// Shared RV32I definitions: major opcodes, ALU operations, immediate formats
// and the decoded-instruction record carried from decode to execute.
package arriskv_pkg;

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OP_IMM = 7'b0010011,
      OPC_OP     = 7'b0110011,
      OPC_FENCE  = 7'b0001111,
      OPC_SYSTEM = 7'b1110011
   } opcode_e;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_B    = 3'd2,
      IMM_U    = 3'd3,
      IMM_J    = 3'd4,
      IMM_NONE = 3'd5
   } imm_type_e;

   localparam int unsigned FUNCT7_BASE = 7'h00;
   localparam int unsigned FUNCT7_ALT  = 7'h20;

   // All-zero encodes a bubble, with alu_op landing on ALU_ADD.
   typedef struct packed {
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      logic        rd_we;
      logic [31:0] imm;
      alu_op_t     alu_op;
      logic        alu_src_imm;
      logic        mem_rd;
      logic        mem_wr;
      logic [2:0]  funct3;
      logic        branch;
      logic        jump;
      logic        illegal;
   } dec_t;

   // alt selects SUB/SRA on the two funct3 codes that have an alternate form.
   function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
      alu_op_t op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/instr_decode_imm_gen.sv
// Combinational immediate generator: sign-extends the immediate of the
// selected RV32I format; IMM_NONE yields zero.
module imm_gen
   import arriskv_pkg::*;
(
   input  logic [31:7] ins,
   input  imm_type_e   imm_type,
   output logic [31:0] o_imm
);

   always_comb begin
      o_imm = '0;
      case (imm_type)
         IMM_I:   o_imm = {{20{ins[31]}}, ins[31:20]};
         IMM_S:   o_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         IMM_B:   o_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         IMM_U:   o_imm = {ins[31:12], 12'b0};
         IMM_J:   o_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: o_imm = '0;
      endcase
   end

endmodule

// File: rtl/instr_decode.sv
// RV32I decode stage: combinational decode of the fetched word followed by a
// single output register with reset > flush > stall > load priority.
module instr_decode
   import arriskv_pkg::*;
#(
   parameter int wd_regs_p    = 32,
   parameter int wd_ramaddr_p = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [wd_regs_p-1:0]    i_fetch_data,
   input  logic [wd_ramaddr_p-1:0] i_pc,
   input  logic                    i_valid,
   input  logic                    i_stall,
   input  logic                    i_flush,
   output logic                    o_valid,
   output logic [wd_ramaddr_p-1:0] o_pc,
   output logic [4:0]              o_rs1_addr,
   output logic [4:0]              o_rs2_addr,
   output logic [4:0]              o_rd_addr,
   output logic                    o_rd_we,
   output logic [wd_regs_p-1:0]    o_imm,
   output alu_op_t                 o_alu_op,
   output logic                    o_alu_src_imm,
   output logic                    o_mem_rd,
   output logic                    o_mem_wr,
   output logic [2:0]              o_funct3,
   output logic                    o_branch,
   output logic                    o_jump,
   output logic                    o_illegal
);

   logic [6:0]  opcode_w;
   logic [4:0]  rd_w;
   logic [4:0]  rs1_w;
   logic [4:0]  rs2_w;
   logic [2:0]  f3_w;
   logic [6:0]  f7_w;
   logic [31:0] imm_w;

   imm_type_e   imm_type_next;
   dec_t        core_next;
   dec_t        dec_next;
   logic        writes_rd_next;
   logic        bad_next;

   dec_t                    dec_reg;
   logic                    valid_reg;
   logic [wd_ramaddr_p-1:0] pc_reg;

   assign opcode_w = i_fetch_data[6:0];
   assign rd_w     = i_fetch_data[11:7];
   assign f3_w     = i_fetch_data[14:12];
   assign rs1_w    = i_fetch_data[19:15];
   assign rs2_w    = i_fetch_data[24:20];
   assign f7_w     = i_fetch_data[31:25];

   always_comb begin
      core_next      = '0;
      imm_type_next  = IMM_NONE;
      writes_rd_next = 1'b0;
      bad_next       = 1'b0;
      case (opcode_w)
         OPC_LUI: begin
            core_next.rd_addr     = rd_w;
            writes_rd_next        = 1'b1;
            imm_type_next         = IMM_U;
            core_next.alu_op      = ALU_PASS_B;
            core_next.alu_src_imm = 1'b1;
         end
         OPC_AUIPC: begin
            core_next.rd_addr     = rd_w;
            writes_rd_next        = 1'b1;
            imm_type_next         = IMM_U;
            core_next.alu_src_imm = 1'b1;
         end
         OPC_JAL: begin
            core_next.rd_addr = rd_w;
            writes_rd_next    = 1'b1;
            imm_type_next     = IMM_J;
            core_next.jump    = 1'b1;
         end
         OPC_JALR: begin
            core_next.rd_addr     = rd_w;
            core_next.rs1_addr    = rs1_w;
            writes_rd_next        = 1'b1;
            imm_type_next         = IMM_I;
            core_next.jump        = 1'b1;
            core_next.alu_src_imm = 1'b1;
            core_next.funct3      = f3_w;
         end
         OPC_BRANCH: begin
            core_next.rs1_addr = rs1_w;
            core_next.rs2_addr = rs2_w;
            imm_type_next      = IMM_B;
            core_next.branch   = 1'b1;
            core_next.alu_op   = ALU_SUB;
            core_next.funct3   = f3_w;
         end
         OPC_LOAD: begin
            core_next.rd_addr     = rd_w;
            core_next.rs1_addr    = rs1_w;
            writes_rd_next        = 1'b1;
            imm_type_next         = IMM_I;
            core_next.mem_rd      = 1'b1;
            core_next.alu_src_imm = 1'b1;
            core_next.funct3      = f3_w;
         end
         OPC_STORE: begin
            core_next.rs1_addr    = rs1_w;
            core_next.rs2_addr    = rs2_w;
            imm_type_next         = IMM_S;
            core_next.mem_wr      = 1'b1;
            core_next.alu_src_imm = 1'b1;
            core_next.funct3      = f3_w;
         end
         OPC_OP_IMM: begin
            core_next.rd_addr     = rd_w;
            core_next.rs1_addr    = rs1_w;
            writes_rd_next        = 1'b1;
            imm_type_next         = IMM_I;
            core_next.alu_src_imm = 1'b1;
            core_next.funct3      = f3_w;
            // Only the right shift reuses imm[10] as an opcode bit (SRAI).
            core_next.alu_op      = alu_from_funct3(f3_w, f7_w[5] && (f3_w == 3'b101));
            if (f3_w == 3'b001 && f7_w != 7'(FUNCT7_BASE))
               bad_next = 1'b1;
            if (f3_w == 3'b101 && f7_w != 7'(FUNCT7_BASE) && f7_w != 7'(FUNCT7_ALT))
               bad_next = 1'b1;
         end
         OPC_OP: begin
            core_next.rd_addr  = rd_w;
            core_next.rs1_addr = rs1_w;
            core_next.rs2_addr = rs2_w;
            writes_rd_next     = 1'b1;
            core_next.funct3   = f3_w;
            core_next.alu_op   = alu_from_funct3(f3_w, f7_w[5]);
            if (f7_w != 7'(FUNCT7_BASE) && f7_w != 7'(FUNCT7_ALT))
               bad_next = 1'b1;
         end
         OPC_FENCE, OPC_SYSTEM: begin
            core_next = '0;
         end
         default: bad_next = 1'b1;
      endcase

      core_next.rd_we = writes_rd_next && (rd_w != 5'd0);

      if (bad_next) begin
         core_next         = '0;
         core_next.illegal = 1'b1;
         imm_type_next     = IMM_NONE;
      end
   end

   imm_gen u_imm_gen (
      .ins      (i_fetch_data[31:7]),
      .imm_type (imm_type_next),
      .o_imm    (imm_w)
   );

   always_comb begin
      dec_next     = core_next;
      dec_next.imm = imm_w;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
         valid_reg <= 1'b0;
         pc_reg    <= '0;
         dec_reg   <= '0;
      end else if (!i_stall) begin
         valid_reg <= i_valid;
         pc_reg    <= i_valid ? i_pc : '0;
         dec_reg   <= i_valid ? dec_next : '0;
      end
   end

   assign o_valid       = valid_reg;
   assign o_pc          = pc_reg;
   assign o_rs1_addr    = dec_reg.rs1_addr;
   assign o_rs2_addr    = dec_reg.rs2_addr;
   assign o_rd_addr     = dec_reg.rd_addr;
   assign o_rd_we       = dec_reg.rd_we;
   assign o_imm         = dec_reg.imm;
   assign o_alu_op      = dec_reg.alu_op;
   assign o_alu_src_imm = dec_reg.alu_src_imm;
   assign o_mem_rd      = dec_reg.mem_rd;
   assign o_mem_wr      = dec_reg.mem_wr;
   assign o_funct3      = dec_reg.funct3;
   assign o_branch      = dec_reg.branch;
   assign o_jump        = dec_reg.jump;
   assign o_illegal     = dec_reg.illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: directed literal cases, then randomized traffic
// compared every cycle against a field-level RV32I decode model.
module tb_instr_decode;
   import arriskv_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] i_fetch_data;
   logic [31:0] i_pc;
   logic        i_valid;
   logic        i_stall;
   logic        i_flush;
   logic        o_valid;
   logic [31:0] o_pc;
   logic [4:0]  o_rs1_addr;
   logic [4:0]  o_rs2_addr;
   logic [4:0]  o_rd_addr;
   logic        o_rd_we;
   logic [31:0] o_imm;
   alu_op_t     o_alu_op;
   logic        o_alu_src_imm;
   logic        o_mem_rd;
   logic        o_mem_wr;
   logic [2:0]  o_funct3;
   logic        o_branch;
   logic        o_jump;
   logic        o_illegal;

   int checks = 0;
   int errors = 0;
   logic model_ready = 1'b0;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic        rd_we;
      logic [31:0] imm;
      alu_op_t     alu_op;
      logic        src_imm, mem_rd, mem_wr;
      logic [2:0]  f3;
      logic        branch, jump, illegal;
   } exp_t;

   exp_t exp_s;

   logic [6:0] opc_tab [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                                7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
   alu_op_t alu_tab [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                            ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

   instr_decode dut (
      .clk(clk), .rst_n(rst_n), .i_fetch_data(i_fetch_data), .i_pc(i_pc),
      .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
      .o_valid(o_valid), .o_pc(o_pc), .o_rs1_addr(o_rs1_addr),
      .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr), .o_rd_we(o_rd_we),
      .o_imm(o_imm), .o_alu_op(o_alu_op), .o_alu_src_imm(o_alu_src_imm),
      .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_funct3(o_funct3),
      .o_branch(o_branch), .o_jump(o_jump), .o_illegal(o_illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t zero_exp();
      exp_t e;
      e.valid = 0; e.pc = 0; e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.rd_we = 0;
      e.imm = 0; e.alu_op = ALU_ADD; e.src_imm = 0; e.mem_rd = 0; e.mem_wr = 0;
      e.f3 = 0; e.branch = 0; e.jump = 0; e.illegal = 0;
      return e;
   endfunction

   // What execute must see for word w, straight from the RV32I field layouts.
   function automatic exp_t model_decode(input logic [31:0] w);
      exp_t        e;
      logic        writes, bad;
      logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
      logic [6:0]  f7;
      e      = zero_exp();
      writes = 0;
      bad    = 0;
      f7     = w[31:25];
      imm_i  = {{20{w[31]}}, w[31:20]};
      imm_s  = {{20{w[31]}}, w[31:25], w[11:7]};
      imm_b  = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      imm_u  = {w[31:12], 12'b0};
      imm_j  = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      e.valid = 1;
      case (w[6:0])
         7'h37: begin e.rd = w[11:7]; writes = 1; e.imm = imm_u; e.alu_op = ALU_PASS_B; e.src_imm = 1; end
         7'h17: begin e.rd = w[11:7]; writes = 1; e.imm = imm_u; e.src_imm = 1; end
         7'h6f: begin e.rd = w[11:7]; writes = 1; e.imm = imm_j; e.jump = 1; end
         7'h67: begin e.rd = w[11:7]; e.rs1 = w[19:15]; writes = 1; e.imm = imm_i;
                      e.jump = 1; e.src_imm = 1; e.f3 = w[14:12]; end
         7'h63: begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = imm_b; e.branch = 1;
                      e.alu_op = ALU_SUB; e.f3 = w[14:12]; end
         7'h03: begin e.rd = w[11:7]; e.rs1 = w[19:15]; writes = 1; e.imm = imm_i;
                      e.mem_rd = 1; e.src_imm = 1; e.f3 = w[14:12]; end
         7'h23: begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = imm_s; e.mem_wr = 1;
                      e.src_imm = 1; e.f3 = w[14:12]; end
         7'h13: begin
            e.rd = w[11:7]; e.rs1 = w[19:15]; writes = 1; e.imm = imm_i; e.src_imm = 1;
            e.f3 = w[14:12]; e.alu_op = alu_tab[w[14:12]];
            if (w[14:12] == 3'd5 && f7 == 7'h20) e.alu_op = ALU_SRA;
            if (w[14:12] == 3'd1 && f7 != 7'h00) bad = 1;
            if (w[14:12] == 3'd5 && f7 != 7'h00 && f7 != 7'h20) bad = 1;
         end
         7'h33: begin
            e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; writes = 1;
            e.f3 = w[14:12]; e.alu_op = alu_tab[w[14:12]];
            if (w[14:12] == 3'd0 && f7 == 7'h20) e.alu_op = ALU_SUB;
            if (w[14:12] == 3'd5 && f7 == 7'h20) e.alu_op = ALU_SRA;
            if (f7 != 7'h00 && f7 != 7'h20) bad = 1;
         end
         7'h0f, 7'h73: ;
         default: bad = 1;
      endcase
      e.rd_we = writes && (w[11:7] != 0);
      if (bad) begin
         e = zero_exp();
         e.valid = 1;
         e.illegal = 1;
      end
      return e;
   endfunction

   task automatic model_update();
      if (!rst_n || i_flush) begin
         exp_s = zero_exp();
         model_ready = 1'b1;
      end else if (!i_stall) begin
         if (i_valid) begin
            exp_s    = model_decode(i_fetch_data);
            exp_s.pc = i_pc;
         end else begin
            exp_s = zero_exp();
         end
      end
   endtask

   task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                       input logic v, input logic st, input logic fl, input logic rn);
      i_fetch_data = ins; i_pc = pc; i_valid = v; i_stall = st; i_flush = fl; rst_n = rn;
      @(posedge clk);
      model_update();
      #1;
      $display("txn ins=%h pc=%h v=%b st=%b fl=%b rn=%b -> valid=%b rd=%0d imm=%h",
               ins, pc, v, st, fl, rn, o_valid, o_rd_addr, o_imm);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   logic [93:0] got_v, want_v;
   logic [6:0]  got_c, want_c;

   always @(negedge clk) begin
      if (model_ready) begin
         checks++;
         if (exp_s.valid) begin
            got_v  = {o_valid, o_pc, o_rs1_addr, o_rs2_addr, o_rd_addr, o_rd_we, o_imm,
                      o_alu_op, o_alu_src_imm, o_mem_rd, o_mem_wr, o_funct3,
                      o_branch, o_jump, o_illegal};
            want_v = {exp_s.valid, exp_s.pc, exp_s.rs1, exp_s.rs2, exp_s.rd, exp_s.rd_we,
                      exp_s.imm, exp_s.alu_op, exp_s.src_imm, exp_s.mem_rd, exp_s.mem_wr,
                      exp_s.f3, exp_s.branch, exp_s.jump, exp_s.illegal};
            if (got_v !== want_v) begin
               errors++;
               $display("FAIL model_cmp @%0t: got %h expected %h", $time, got_v, want_v);
            end
         end else begin
            got_c  = {o_valid, o_rd_we, o_mem_rd, o_mem_wr, o_branch, o_jump, o_illegal};
            want_c = {exp_s.valid, exp_s.rd_we, exp_s.mem_rd, exp_s.mem_wr,
                      exp_s.branch, exp_s.jump, exp_s.illegal};
            if (got_c !== want_c) begin
               errors++;
               $display("FAIL model_bubble @%0t: got %b expected %b", $time, got_c, want_c);
            end
         end
      end
   end

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int          sel;
      w   = $urandom;
      sel = $urandom_range(0, 12);
      if (sel < 11) w[6:0] = opc_tab[sel];
      if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
         case ($urandom_range(0, 3))
            0, 1:    w[31:25] = 7'h00;
            2:       w[31:25] = 7'h20;
            default: ;
         endcase
      end
      return w;
   endfunction

   initial begin
      logic [31:0] r_ins, r_pc;
      step(32'h0, 32'h0, 0, 0, 0, 0);
      chk("reset_valid", o_valid, 0);
      chk("reset_pc", o_pc, 0);
      chk("reset_imm", o_imm, 0);
      chk("reset_alu", o_alu_op, ALU_ADD);
      chk("reset_rd", o_rd_addr, 0);

      step(32'h00500093, 32'h100, 1, 0, 0, 1);
      chk("addi_valid", o_valid, 1);
      chk("addi_rd", o_rd_addr, 1);
      chk("addi_rs1", o_rs1_addr, 0);
      chk("addi_imm", o_imm, 5);
      chk("addi_alu", o_alu_op, ALU_ADD);
      chk("addi_srcimm", o_alu_src_imm, 1);
      chk("addi_rdwe", o_rd_we, 1);
      chk("addi_pc", o_pc, 32'h100);

      step(32'h0080A103, 32'h104, 1, 0, 0, 0);
      chk("rst_mid_valid", o_valid, 0);
      chk("rst_mid_rdwe", o_rd_we, 0);
      chk("rst_mid_imm", o_imm, 0);
      step(32'h00500093, 32'h200, 1, 0, 0, 1);
      chk("post_rst_rd", o_rd_addr, 1);
      chk("post_rst_imm", o_imm, 5);

      step(32'hFE208EE3, 32'h204, 1, 0, 0, 1);
      chk("beq_rs1", o_rs1_addr, 1);
      chk("beq_rs2", o_rs2_addr, 2);
      chk("beq_imm", o_imm, 32'hFFFFFFFC);
      chk("beq_branch", o_branch, 1);
      chk("beq_f3", o_funct3, 0);
      chk("beq_rdwe", o_rd_we, 0);

      step(32'h0080A103, 32'h208, 1, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         r_ins = rand_instr();
         step(r_ins, 32'h300, 1, 1, 0, 1);
         chk("lw_hold_memrd", o_mem_rd, 1);
         chk("lw_hold_imm", o_imm, 8);
         chk("lw_hold_rd", o_rd_addr, 2);
      end

      step(32'h123452B7, 32'h20C, 1, 1, 1, 1);
      chk("flush_valid", o_valid, 0);
      chk("flush_enables", {o_rd_we, o_mem_rd, o_mem_wr, o_branch, o_jump, o_illegal}, 0);

      step(32'hFFFFFFFF, 32'h210, 1, 0, 0, 1);
      chk("ill_illegal", o_illegal, 1);
      chk("ill_valid", o_valid, 1);
      chk("ill_enables", {o_rd_we, o_mem_rd, o_mem_wr}, 0);

      step(32'h00100013, 32'h214, 1, 0, 0, 1);
      chk("x0_rdwe", o_rd_we, 0);
      step(32'h00100013, 32'h218, 0, 0, 0, 1);
      chk("bubble_valid", o_valid, 0);

      for (int n = 0; n < 1500; n++) begin
         r_ins = rand_instr();
         r_pc  = $urandom;
         r_pc[1:0] = 2'b00;
         step(r_ins, r_pc, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20,
              $urandom_range(0, 99) < 8, $urandom_range(0, 99) != 0);
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
